// File: rtl/mbist_mux_pkg.sv
// mbist_mux_pkg
// Shared types for the MBIST / functional memory mux:
//   mux_state_e    - ownership FSM state (functional, draining, BIST)
//   repair_entry_t - one row-repair table entry (valid + failing address)
//   rr_next()      - round-robin pointer advance with wrap
// Repair addresses are held at REPAIR_ADDR_MAX_WD bits so the struct can
// live in a non-parameterised package; narrower addresses are zero-extended.
package mbist_mux_pkg;

    typedef enum logic [1:0] {
        ST_FUNC  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_BIST  = 2'd2
    } mux_state_e;

    localparam int REPAIR_ADDR_MAX_WD = 16;

    typedef struct packed {
        logic                          valid;
        logic [REPAIR_ADDR_MAX_WD-1:0] addr;
    } repair_entry_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mbist_rr_arb.sv
// mbist_rr_arb
// Round-robin arbiter, single grant per cycle, combinational grant in the
// same cycle as the request. After a grant the pointer moves to the
// granted index + 1 (mod NUM_PORT), so the winner has lowest priority next.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (pointer -> 0)
//   en          arbitration enable; no grant and no pointer move when low
//   req         per-port request
//   gnt         one-hot grant (or zero)
//   gnt_idx     binary index of the granted port
//   gnt_vld     a grant was issued this cycle
import mbist_mux_pkg::*;

module mbist_rr_arb #(
    parameter  int NUM_PORT = 2,
    localparam int IDX_WD   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_PORT-1:0] req,
    output logic [NUM_PORT-1:0] gnt,
    output logic [IDX_WD-1:0]   gnt_idx,
    output logic                gnt_vld
);

    logic [IDX_WD-1:0] ptr;
    int                p;

    // Scan ports starting at ptr; first requester found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        p       = 0;
        for (int k = 0; k < NUM_PORT; k++) begin
            p = int'(ptr) + k;
            if (p >= NUM_PORT) p = p - NUM_PORT;
            if (en && !gnt_vld && req[p]) begin
                gnt_vld = 1'b1;
                gnt[p]  = 1'b1;
                gnt_idx = IDX_WD'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (gnt_vld)
            ptr <= IDX_WD'(rr_next(32'(gnt_idx), NUM_PORT));
    end

endmodule

// File: rtl/mbist_mux_arb.sv
// mbist_mux_arb
// Shares one single-port memory between NUM_PORT functional requesters
// (round-robin) and an MBIST engine. bist_en hands the memory to BIST after
// in-flight functional reads have drained. Optional row repair: BIST-reported
// failing addresses are remapped onto spare rows starting at
// BIST_REPAIR_ADDR_START, in every state.
// Build option: define MBIST_MUX_REPAIR_EN to build the repair table;
// without it mem_addr is the selected address and bist_correct is 1.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   scan_mode                       func_rdata = mem_din when 1
//   bist_en / bist_ready            BIST ownership request / granted
//   bist_addr, bist_wdata           BIST address / write data
//   bist_wr, bist_rd                BIST write / read strobes
//   bist_error, bist_error_addr     failing-address report from BIST
//   bist_correct                    all reported failures repairable
//   func_req, func_we, func_mask    per-port request / write enable / byte mask
//   func_addr, func_wdata           per-port address / write data
//   func_gnt, func_rvalid           per-port grant / read data valid
//   func_rdata                      shared read data
//   mem_cen, mem_web                active-low chip / write enable
//   mem_mask, mem_addr, mem_din     memory byte mask / address / data in
//   mem_dout                        memory read data (RD_LAT after access)
import mbist_mux_pkg::*;

module mbist_mux_arb #(
    parameter  int                    NUM_PORT               = 2,
    parameter  int                    BIST_ADDR_WD           = 9,
    parameter  int                    BIST_DATA_WD           = 32,
    parameter  int                    RD_LAT                 = 1,
    parameter  int                    REPAIR_DEPTH           = 4,
    parameter  logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1FC,
    localparam int                    MASK_WD                = BIST_DATA_WD / 8,
    localparam int                    IDX_WD                 = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   scan_mode,
    input  logic                                   bist_en,
    output logic                                   bist_ready,
    input  logic [BIST_ADDR_WD-1:0]                bist_addr,
    input  logic [BIST_DATA_WD-1:0]                bist_wdata,
    input  logic                                   bist_wr,
    input  logic                                   bist_rd,
    input  logic                                   bist_error,
    input  logic [BIST_ADDR_WD-1:0]                bist_error_addr,
    output logic                                   bist_correct,
    input  logic [NUM_PORT-1:0]                    func_req,
    input  logic [NUM_PORT-1:0]                    func_we,
    input  logic [NUM_PORT-1:0][MASK_WD-1:0]       func_mask,
    input  logic [NUM_PORT-1:0][BIST_ADDR_WD-1:0]  func_addr,
    input  logic [NUM_PORT-1:0][BIST_DATA_WD-1:0]  func_wdata,
    output logic [NUM_PORT-1:0]                    func_gnt,
    output logic [NUM_PORT-1:0]                    func_rvalid,
    output logic [BIST_DATA_WD-1:0]                func_rdata,
    output logic                                   mem_cen,
    output logic                                   mem_web,
    output logic [MASK_WD-1:0]                     mem_mask,
    output logic [BIST_ADDR_WD-1:0]                mem_addr,
    output logic [BIST_DATA_WD-1:0]                mem_din,
    input  logic [BIST_DATA_WD-1:0]                mem_dout
);

    mux_state_e                   state;
    logic                         bist_ready_q;
    logic [NUM_PORT-1:0]          gnt;
    logic [IDX_WD-1:0]            gnt_idx;
    logic                         gnt_vld;
    logic                         rd_launch;
    logic [RD_LAT:1]              vld_pipe;
    logic [RD_LAT:1][IDX_WD-1:0]  idx_pipe;
    logic                         pipe_empty;
    logic [BIST_ADDR_WD-1:0]      sel_addr;
    logic                         mem_cen_raw;

    // ---------------------------------------------------------------- arbiter
    mbist_rr_arb #(.NUM_PORT(NUM_PORT)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rst_n && state == ST_FUNC),
        .req     (func_req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign func_gnt = gnt;

    // ------------------------------------------------------- read pipeline
    // vld_pipe[s] is high s cycles after a granted read; the tag rides along
    // so the returning data is attributed to the right port.
    assign rd_launch  = gnt_vld && !func_we[gnt_idx];
    assign pipe_empty = ~|vld_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_launch;
            idx_pipe[1] <= gnt_idx;
            for (int s = 2; s <= RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    always_comb begin
        func_rvalid = '0;
        if (rst_n && vld_pipe[RD_LAT])
            func_rvalid[idx_pipe[RD_LAT]] = 1'b1;
    end

    assign func_rdata = scan_mode ? mem_din : mem_dout;

    // --------------------------------------------------------------- FSM
    // DRAIN waits until no functional read is still in flight, so BIST never
    // collides with returning data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_FUNC;
            bist_ready_q <= 1'b0;
        end else begin
            case (state)
                ST_FUNC: begin
                    if (bist_en) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!bist_en) begin
                        state <= ST_FUNC;
                    end else if (pipe_empty) begin
                        state        <= ST_BIST;
                        bist_ready_q <= 1'b1;
                    end
                end
                ST_BIST: begin
                    if (!bist_en) begin
                        state        <= ST_FUNC;
                        bist_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_FUNC;
                    bist_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bist_ready = bist_ready_q && rst_n;

    // ------------------------------------------------------- memory mux
    always_comb begin
        sel_addr    = func_addr[gnt_idx];
        mem_cen_raw = 1'b1;
        mem_web     = 1'b1;
        mem_mask    = '0;
        mem_din     = func_wdata[gnt_idx];
        case (state)
            ST_FUNC: begin
                mem_cen_raw = !gnt_vld;
                mem_web     = !(gnt_vld && func_we[gnt_idx]);
                mem_mask    = func_mask[gnt_idx];
            end
            ST_BIST: begin
                sel_addr    = bist_addr;
                mem_cen_raw = !(bist_rd || bist_wr);
                mem_web     = !bist_wr;
                mem_mask    = '1;
                mem_din     = bist_wdata;
            end
            default: ;
        endcase
    end

    // Reset is synchronous, so the memory is held off combinationally while
    // rst_n is low rather than waiting for the edge.
    assign mem_cen = mem_cen_raw || !rst_n;

    // ------------------------------------------------------- repair table
`ifdef MBIST_MUX_REPAIR_EN
    localparam int REP_IDX_WD = (REPAIR_DEPTH > 1) ? $clog2(REPAIR_DEPTH) : 1;

    repair_entry_t [REPAIR_DEPTH-1:0] rep_tbl;
    logic                             bist_correct_q;
    logic                             err_hit;
    logic                             free_vld;
    logic [REP_IDX_WD-1:0]            free_idx;
    logic                             map_hit;
    logic [REP_IDX_WD-1:0]            map_idx;

    // Descending scan: the last assignment is the lowest index, so the
    // lowest matching entry wins the remap and the lowest free slot fills.
    always_comb begin
        err_hit  = 1'b0;
        free_vld = 1'b0;
        free_idx = '0;
        map_hit  = 1'b0;
        map_idx  = '0;
        for (int i = REPAIR_DEPTH - 1; i >= 0; i--) begin
            if (rep_tbl[i].valid && rep_tbl[i].addr == REPAIR_ADDR_MAX_WD'(sel_addr)) begin
                map_hit = 1'b1;
                map_idx = REP_IDX_WD'(i);
            end
            if (rep_tbl[i].valid && rep_tbl[i].addr == REPAIR_ADDR_MAX_WD'(bist_error_addr))
                err_hit = 1'b1;
            if (!rep_tbl[i].valid) begin
                free_vld = 1'b1;
                free_idx = REP_IDX_WD'(i);
            end
        end
    end

    assign mem_addr = map_hit ? (BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(map_idx)) : sel_addr;

    // Overflow (new address, no free slot) is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_tbl        <= '0;
            bist_correct_q <= 1'b1;
        end else if (state == ST_BIST && bist_error && !err_hit) begin
            if (free_vld) begin
                rep_tbl[free_idx].valid <= 1'b1;
                rep_tbl[free_idx].addr  <= REPAIR_ADDR_MAX_WD'(bist_error_addr);
            end else begin
                bist_correct_q <= 1'b0;
            end
        end
    end

    assign bist_correct = bist_correct_q;
`else
    logic unused_repair;
    assign unused_repair = ^{bist_error, bist_error_addr, BIST_REPAIR_ADDR_START, 32'(REPAIR_DEPTH)};
    assign mem_addr      = sel_addr;
    assign bist_correct  = 1'b1;
`endif

endmodule

// File: tb/tb_mbist_mux_arb.sv
module tb_mbist_mux_arb;

`ifdef MBIST_MUX_REPAIR_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             scan_mode;
  logic             bist_en;
  logic             bist_ready;
  logic [8:0]       bist_addr;
  logic [31:0]      bist_wdata;
  logic             bist_wr;
  logic             bist_rd;
  logic             bist_error;
  logic [8:0]       bist_error_addr;
  logic             bist_correct;
  logic [1:0]       func_req;
  logic [1:0]       func_we;
  logic [1:0][3:0]  func_mask;
  logic [1:0][8:0]  func_addr;
  logic [1:0][31:0] func_wdata;
  logic [1:0]       func_gnt;
  logic [1:0]       func_rvalid;
  logic [31:0]      func_rdata;
  logic             mem_cen;
  logic             mem_web;
  logic [3:0]       mem_mask;
  logic [8:0]       mem_addr;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mbist_mux_arb #(.NUM_PORT(2), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .scan_mode(scan_mode),
    .bist_en(bist_en), .bist_ready(bist_ready),
    .bist_addr(bist_addr), .bist_wdata(bist_wdata),
    .bist_wr(bist_wr), .bist_rd(bist_rd),
    .bist_error(bist_error), .bist_error_addr(bist_error_addr),
    .bist_correct(bist_correct),
    .func_req(func_req), .func_we(func_we), .func_mask(func_mask),
    .func_addr(func_addr), .func_wdata(func_wdata),
    .func_gnt(func_gnt), .func_rvalid(func_rvalid), .func_rdata(func_rdata),
    .mem_cen(mem_cen), .mem_web(mem_web), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  logic [31:0]  mem [512];
  bit   [511:0] written;
  logic [31:0]  rd0 = '0;
  logic [31:0]  rd1 = '0;

  function automatic logic [31:0] rd_word(input logic [8:0] a);
    return written[a] ? mem[a] : (32'hA500_0000 | {23'd0, a});
  endfunction

  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_web) begin
        logic [31:0] w;
        w = rd_word(mem_addr);
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) w[b*8 +: 8] = mem_din[b*8 +: 8];
        mem[mem_addr]     <= w;
        written[mem_addr] <= 1'b1;
      end else begin
        rd0 <= rd_word(mem_addr);
      end
    end
    rd1 <= rd0;
  end
  assign mem_dout = rd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: stimulus did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0; scan_mode = 1'b0; bist_en = 1'b0;
    bist_addr = '0; bist_wdata = '0; bist_wr = 1'b0; bist_rd = 1'b0;
    bist_error = 1'b0; bist_error_addr = '0;
    func_req = 2'b11; func_we = 2'b00; func_mask = '1;
    func_addr[0] = 9'h004; func_addr[1] = 9'h008;
    func_wdata = '0;

    go(); look();
    chk("rst_gnt", func_gnt, 2'b00);
    chk("rst_rvalid", func_rvalid, 2'b00);
    chk("rst_cen", mem_cen, 1'b1);
    chk("rst_ready", bist_ready, 1'b0);
    chk("rst_correct", bist_correct, 1'b1);

    go(); rst_n = 1'b1; look();
    chk("a0_gnt", func_gnt, 2'b01);
    chk("a0_addr", mem_addr, 9'h004);
    chk("a0_cen", mem_cen, 1'b0);
    chk("a0_web", mem_web, 1'b1);
    go(); look();
    chk("a1_gnt", func_gnt, 2'b10);
    chk("a1_addr", mem_addr, 9'h008);
    chk("a1_rvalid", func_rvalid, 2'b00);
    go(); look();
    chk("a2_gnt", func_gnt, 2'b01);
    chk("a2_rvalid", func_rvalid, 2'b01);
    chk("a2_rdata", func_rdata, 32'hA500_0004);
    go(); func_req = 2'b00; look();
    chk("a3_gnt", func_gnt, 2'b00);
    chk("a3_cen", mem_cen, 1'b1);
    chk("a3_rvalid", func_rvalid, 2'b10);
    chk("a3_rdata", func_rdata, 32'hA500_0008);
    go(); look();
    chk("a4_rvalid", func_rvalid, 2'b01);
    chk("a4_rdata", func_rdata, 32'hA500_0004);
    go(); look();
    chk("a5_rvalid", func_rvalid, 2'b00);

    go(); func_req = 2'b01; func_we = 2'b01; func_addr[0] = 9'h030;
    func_wdata[0] = 32'h1234_5678; func_mask[0] = 4'b0011; look();
    chk("w0_gnt", func_gnt, 2'b01);
    chk("w0_web", mem_web, 1'b0);
    chk("w0_mask", mem_mask, 4'b0011);
    chk("w0_din", mem_din, 32'h1234_5678);
    go(); func_req = 2'b10; func_we = 2'b00; func_mask = '1;
    func_addr[1] = 9'h030; func_addr[0] = 9'h004; look();
    chk("w1_gnt", func_gnt, 2'b10);
    chk("w1_addr", mem_addr, 9'h030);
    go(); func_req = 2'b11; look();
    chk("w2_gnt", func_gnt, 2'b01);
    chk("w2_rvalid_wr", func_rvalid, 2'b00);
    go(); func_req = 2'b00; look();
    chk("w3_rvalid", func_rvalid, 2'b10);
    chk("w3_rdata", func_rdata, 32'hA500_5678);
    go(); look();
    chk("w4_rvalid", func_rvalid, 2'b01);

    go(); func_req = 2'b10; func_addr[1] = 9'h008; look();
    chk("d0_gnt", func_gnt, 2'b10);
    go(); func_req = 2'b00; bist_en = 1'b1; look();
    chk("d1_ready", bist_ready, 1'b0);
    go(); func_req = 2'b11; look();
    chk("d2_gnt", func_gnt, 2'b00);
    chk("d2_cen", mem_cen, 1'b1);
    chk("d2_rvalid", func_rvalid, 2'b10);
    chk("d2_rdata", func_rdata, 32'hA500_0008);
    chk("d2_ready", bist_ready, 1'b0);
    go(); func_req = 2'b00; look();
    chk("d3_ready", bist_ready, 1'b0);
    go(); look();
    chk("d4_ready", bist_ready, 1'b1);
    chk("d4_cen", mem_cen, 1'b1);

    go(); bist_wr = 1'b1; bist_addr = 9'h044; bist_wdata = 32'hDEAD_BEEF; scan_mode = 1'b1; look();
    chk("b0_cen", mem_cen, 1'b0);
    chk("b0_web", mem_web, 1'b0);
    chk("b0_mask", mem_mask, 4'hF);
    chk("b0_addr", mem_addr, 9'h044);
    chk("b0_scan", func_rdata, 32'hDEAD_BEEF);
    go(); bist_wr = 1'b0; bist_rd = 1'b1; scan_mode = 1'b0; look();
    chk("b1_web", mem_web, 1'b1);
    chk("b1_cen", mem_cen, 1'b0);
    go(); bist_rd = 1'b0; look();
    chk("b2_cen", mem_cen, 1'b1);
    go(); look();
    chk("b3_rdata", func_rdata, 32'hDEAD_BEEF);
    chk("b3_rvalid", func_rvalid, 2'b00);

    go(); bist_error = 1'b1; bist_error_addr = 9'h010;
    go();
    go(); bist_error_addr = 9'h020;
    go(); bist_error = 1'b0; bist_rd = 1'b1; bist_addr = 9'h020; look();
    chk("e_map020", mem_addr, REP ? 9'h1FD : 9'h020);
    chk("e_correct", bist_correct, 1'b1);
    go(); bist_addr = 9'h010; look();
    chk("e_map010", mem_addr, REP ? 9'h1FC : 9'h010);
    go(); bist_addr = 9'h030; bist_rd = 1'b0; bist_error = 1'b1; bist_error_addr = 9'h050; look();
    chk("e_nomap", mem_addr, 9'h030);
    go(); bist_error_addr = 9'h060;
    go(); bist_error_addr = 9'h070; look();
    chk("e_full_ok", bist_correct, 1'b1);
    go(); bist_error = 1'b0; look();
    chk("e_overflow", bist_correct, REP ? 1'b0 : 1'b1);
    go(); bist_en = 1'b0; look();
    chk("e_ready_hold", bist_ready, 1'b1);
    go(); look();
    chk("e_ready_off", bist_ready, 1'b0);
    chk("e_sticky", bist_correct, REP ? 1'b0 : 1'b1);

    go(); func_req = 2'b01; func_addr[0] = 9'h010; look();
    chk("f_gnt", func_gnt, 2'b01);
    chk("f_map010", mem_addr, REP ? 9'h1FC : 9'h010);
    go(); func_req = 2'b00; bist_en = 1'b1;
    go(); go(); go(); look();
    chk("r_ready", bist_ready, 1'b1);

    go(); rst_n = 1'b0; bist_rd = 1'b1; bist_addr = 9'h010; func_req = 2'b11; look();
    chk("rb_gnt", func_gnt, 2'b00);
    chk("rb_cen", mem_cen, 1'b1);
    chk("rb_ready", bist_ready, 1'b0);
    go(); rst_n = 1'b1; bist_rd = 1'b0; look();
    chk("ra_gnt", func_gnt, 2'b01);
    chk("ra_addr", mem_addr, 9'h010);
    chk("ra_correct", bist_correct, 1'b1);
    chk("ra_ready", bist_ready, 1'b0);

    go(); func_req = 2'b00; rst_n = 1'b0; look();
    chk("rd_rvalid", func_rvalid, 2'b00);
    go(); rst_n = 1'b1; bist_en = 1'b0; look();
    chk("rd_dropped", func_rvalid, 2'b00);
    chk("rd_ready", bist_ready, 1'b0);
    go(); look();
    chk("rd_quiet", func_rvalid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbist_mux_arb.md
MBIST_MUX_ARB -- requirements
Module: mbist_mux_arb

Interface
REQ-001 The block SHALL have parameter NUM_PORT, default 2, meaning the number of functional requester ports.
REQ-002 The block SHALL have parameter BIST_ADDR_WD, default 9, meaning the memory address width.
REQ-003 The block SHALL have parameter BIST_DATA_WD, default 32, meaning the data width, with mask width BIST_DATA_WD/8.
REQ-004 The block SHALL have parameter RD_LAT, default 1, meaning the memory read latency in clk cycles (range 1..4).
REQ-005 The block SHALL have parameter REPAIR_DEPTH, default 4, meaning the number of repair entries.
REQ-006 The block SHALL have parameter BIST_REPAIR_ADDR_START, default 9'h1FC, meaning the first spare row address.
REQ-007 The block SHALL have these ports, one per line (name  direction  width  meaning); clk and rst_n are fixed as: one clock; reset is synchronous and active-low.
 clk  in  1  single clock for all logic and for the memory
 rst_n  in  1  reset, synchronous, active-low
 scan_mode  in  1  forces func_rdata = mem_din
 bist_en  in  1  BIST ownership request
 bist_ready  out  1  BIST owns memory
 bist_addr / bist_wdata  in  ADDR_WD / DATA_WD  BIST address and write data
 bist_wr / bist_rd  in  1  BIST write / read strobes
 bist_error / bist_error_addr  in  1 / ADDR_WD  failing address report
 bist_correct  out  1  all failures repairable
 func_req / func_we  in  NUM_PORT  per-port request / write-enable
 func_mask  in  NUM_PORT x DATA_WD/8  byte masks
 func_addr / func_wdata  in  NUM_PORT x ADDR_WD / DATA_WD  per-port address / data
 func_gnt / func_rvalid  out  NUM_PORT  grant / read-data-valid
 func_rdata  out  DATA_WD  shared read data
 mem_cen / mem_web  out  1  active-low chip enable / write enable
 mem_mask / mem_addr / mem_din  out  mask / ADDR_WD / DATA_WD  memory inputs
 mem_dout  in  DATA_WD  memory read data

Function
REQ-008 The FSM SHALL have states FUNC, DRAIN and BIST, with FUNC->DRAIN on bist_en=1, DRAIN->BIST when the read pipeline is empty, and BIST or DRAIN->FUNC on bist_en=0 in the next cycle.
REQ-009 In FUNC, the block SHALL grant exactly one requesting port per cycle, same cycle as func_req, round-robin, with the pointer moving to the granted index+1 modulo NUM_PORT.
REQ-010 In DRAIN and BIST, func_gnt SHALL be 0 and mem_cen SHALL be 1 except for BIST accesses in BIST.
REQ-011 A granted read SHALL assert func_rvalid on the granting port exactly RD_LAT cycles later, with func_rdata = mem_dout; rvalid SHALL be one-hot or zero.
REQ-012 In BIST, mem_cen SHALL be !(bist_rd|bist_wr), mem_web SHALL be !bist_wr, and mem_mask SHALL be all ones; bist_ready SHALL be 1 only in BIST.
REQ-013 In BIST, on bist_error=1 with an unmatched bist_error_addr and a free entry, the block SHALL store the address in the next entry; a duplicate address SHALL not be stored.
REQ-014 On bist_error with all entries used and an unmatched address, bist_correct SHALL clear and stay 0 until reset (sticky overflow).
REQ-015 In all states, mem_addr SHALL be BIST_REPAIR_ADDR_START+i when the selected address matches valid entry i (lowest i wins), and the selected address otherwise.
REQ-016 When scan_mode=1, func_rdata SHALL equal mem_din.

Reset
REQ-017 With rst_n=0 at a clk edge, the block SHALL enter FUNC, set the RR pointer to 0, flush the read pipeline, clear the repair table, and set bist_correct=1.
REQ-018 During reset, func_gnt, func_rvalid and bist_ready SHALL be 0 and mem_cen SHALL be 1; reset mid-drain SHALL drop in-flight reads without rvalid.

Configuration
REQ-019 With macro MBIST_MUX_REPAIR_EN defined, the repair table SHALL be built per REQ-013..015; undefined, mem_addr SHALL equal the selected address, bist_correct SHALL be tied to 1, and no table flops SHALL exist.

Structure
REQ-020 A shared package mbist_mux_pkg SHALL hold the FSM state enum and the repair-entry struct (valid, addr).
REQ-021 The round-robin arbiter SHALL be sub-module mbist_rr_arb, parametrised by NUM_PORT.

Verification
REQ-022 Verification: ports 0 and 1 request continuously -> grants alternate 0,1,0,1, and rvalid follows each read by RD_LAT.
REQ-023 Verification: bist_en rises one cycle after a port-1 read with RD_LAT=2 -> bist_ready=1 only after that read's rvalid.
REQ-024 Verification: errors at 9'h010, 9'h010, 9'h020 -> two entries stored, and a BIST read of 9'h020 drives mem_addr=9'h1FD.
REQ-025 Verification: five distinct errors with REPAIR_DEPTH=4 -> bist_correct=0 after the fifth error and held until reset.
REQ-026 Verification: rst_n=0 mid-BIST -> FUNC state, table cleared, and 9'h010 no longer remapped.
REQ-027 Verification: build without MBIST_MUX_REPAIR_EN -> mem_addr equals the requested address and bist_correct=1 throughout.
